// File: rtl/testport_pkg.sv
// Shared types and defaults for the test-port capture block.
// FSM encoding, default symbols and port address live here.
package testport_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_DONE  = 2'b10
  } tp_state_e;

  localparam logic [29:0] TP_PORT_ADDR = 30'h40;
  localparam logic [31:0] TP_BEGIN_SYM = 32'h0000_0932;
  localparam logic [31:0] TP_END_SYM   = 32'h0000_0D5D;
  localparam int unsigned TP_STAMP_W   = 16;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tp_fifo.sv
// Small synchronous FIFO with registered storage and extra-bit pointers.
// Push while full succeeds only when a pop happens in the same cycle.
module tp_fifo
  import testport_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/testport_capture.sv
// Captures CPU stores to the test port between BEGIN/END symbols.
// Optional TESTPORT_STAMP_EN adds a per-entry cycle stamp output.
module testport_capture
  import testport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = TP_PORT_ADDR,
  parameter logic [31:0] BEGIN_SYMBOL = TP_BEGIN_SYM,
  parameter logic [31:0] END_SYMBOL   = TP_END_SYM,
  parameter int          DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wen,
  input  logic        mem_stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
`ifdef TESTPORT_STAMP_EN
  output logic [15:0] out_stamp,
`endif
  output logic        armed,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

`ifdef TESTPORT_STAMP_EN
  localparam int FW = 32 + TP_STAMP_W;
`else
  localparam int FW = 32;
`endif

  tp_state_e     state_q;
  tp_state_e     state_d;
  logic          hold_q;
  logic          qs;
  logic          capture;
  logic          pop;
  logic          full;
  logic          empty;
  logic [FW-1:0] f_wdata;
  logic [FW-1:0] f_rdata;

  // A held store counts once, on its first unstalled cycle.
  assign qs = mem_wen & ~mem_stall &
              (mem_addr == TEST_PORT) & ~hold_q;

  assign capture   = qs & (state_q == ST_ARMED);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

`ifdef TESTPORT_STAMP_EN
  logic [15:0] cyc_q;

  assign f_wdata   = {cyc_q, mem_wdata};
  assign out_data  = f_rdata[31:0];
  assign out_stamp = f_rdata[FW-1:32];

  // Cycles spent in ARMED; frozen once DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (state_q == ST_ARMED) begin
      cyc_q <= sat_inc16(cyc_q);
    end
  end
`else
  assign f_wdata  = mem_wdata;
  assign out_data = f_rdata;
`endif

  // Hold blocks re-counting a store across stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
    end else if (!mem_wen) begin
      hold_q <= 1'b0;
    end else if (qs) begin
      hold_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status flags.
  always_comb begin
    state_d = state_q;
    armed   = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (qs && mem_wdata == BEGIN_SYMBOL)
          state_d = ST_ARMED;
      end
      (state_q == ST_ARMED): begin
        armed = 1'b1;
        if (qs && mem_wdata == END_SYMBOL)
          state_d = ST_DONE;
      end
      (state_q == ST_DONE): begin
        done = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word count and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (capture) begin
      word_count <= sat_inc8(word_count);
      if (full && !pop) overflow <= 1'b1;
    end
  end

  tp_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata (f_wdata),
    .rdata (f_rdata),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_testport_capture.sv
// Bench for testport_capture: queue model plus directed stores.
// Default DUT parameters (port 0x40, DEPTH 8) are assumed.
module tb_testport_capture;
  import testport_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_wen = 1'b0;
  logic        mem_stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        armed;
  logic        done;
  logic        overflow;
  logic [7:0]  word_count;
`ifdef TESTPORT_STAMP_EN
  logic [15:0] out_stamp;
`endif

  int n_asserts = 0;
  int n_fail = 0;

  testport_capture dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_stall  (mem_stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef TESTPORT_STAMP_EN
    .out_stamp  (out_stamp),
`endif
    .armed      (armed),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: queue of pending words and scalar status.
  logic [31:0] mq[$];
  logic [15:0] msq[$];
  int          m_state;
  int          m_cnt;
  bit          m_ovf;
  bit          m_hold;
  int          m_cyc;
  int          m_prev;
  bit          m_qs;
  bit          m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      msq.delete();
      m_state = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_hold = 0;
      m_cyc = 0;
    end else begin
      m_prev = m_state;
      m_pop = (mq.size() != 0) && out_ready;
      m_qs = mem_wen && !mem_stall &&
             mem_addr == 30'h40 && !m_hold;
      if (!mem_wen) m_hold = 0;
      else if (m_qs) m_hold = 1;
      if (m_pop) begin
        void'(mq.pop_front());
        void'(msq.pop_front());
      end
      if (m_qs && m_prev == 0) begin
        if (mem_wdata == 32'h932) m_state = 1;
      end else if (m_qs && m_prev == 1) begin
        if (m_cnt < 255) m_cnt++;
        if (mq.size() < 8) begin
          mq.push_back(mem_wdata);
          msq.push_back(16'(m_cyc));
        end else begin
          m_ovf = 1;
        end
        if (mem_wdata == 32'hD5D) m_state = 2;
      end
      if (m_prev == 1 && m_cyc < 65535) m_cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
`ifdef TESTPORT_STAMP_EN
    if (msq.size() != 0) chk("out_stamp", 32'(out_stamp), 32'(msq[0]));
`endif
    chk("armed", 32'(armed), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("word_count", 32'(word_count), 32'(m_cnt));
  end

  // Log of words actually handed to the checker.
  logic [31:0] log_q[$];
  logic [15:0] slog_q[$];

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      log_q.push_back(out_data);
`ifdef TESTPORT_STAMP_EN
      slog_q.push_back(out_stamp);
`else
      slog_q.push_back(16'h0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_wen = 1'b0;
    mem_stall = 1'b0;
    out_ready = 1'b0;
    tick(2);
    log_q.delete();
    slog_q.delete();
    rst = 1'b1;
    tick(1);
  endtask

  task automatic store(input logic [29:0] a,
                       input logic [31:0] d,
                       input int stalls,
                       input int extra);
    mem_addr = a;
    mem_wdata = d;
    mem_wen = 1'b1;
    mem_stall = (stalls > 0);
    tick(stalls);
    mem_stall = 1'b0;
    tick(1 + extra);
    mem_wen = 1'b0;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq [5];
    seq = '{32'h0, 32'h1, 32'h1, 32'h2, 32'hD5D};

    // Reset state.
    tick(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick(1);

    // Stores before BEGIN or off-port are ignored.
    out_ready = 1'b1;
    store(30'h41, 32'h932, 0, 0);
    store(30'h40, 32'h5, 0, 0);
    store(30'h40, 32'h7, 1, 0);
    store(30'h41, 32'h3, 0, 0);
    tick(2);
    chk("pre_armed", 32'(armed), 32'd0);
    chk("pre_log", 32'(log_q.size()), 32'd0);

    // Basic capture sequence ending with END.
    store(30'h40, 32'h932, 0, 0);
    chk("arm", 32'(armed), 32'd1);
    for (int i = 0; i < 5; i++) store(30'h40, seq[i], 0, 0);
    tick(2);
    chk("seq_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk("seq_word", log_q[i], seq[i]);
    chk("seq_wc", 32'(word_count), 32'd5);
    chk("seq_done", 32'(done), 32'd1);
    store(30'h40, 32'h9, 0, 0);
    tick(2);
    chk("done_ignore", 32'(log_q.size()), 32'd5);

    // One store held across 4 stall cycles plus 2 extra.
    do_reset();
    out_ready = 1'b1;
    store(30'h40, 32'h932, 0, 0);
    store(30'h40, 32'h5, 4, 2);
    tick(2);
    chk("stall_len", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("stall_word", log_q[0], 32'h5);
    chk("stall_wc", 32'(word_count), 32'd1);

    // Nine stores into a full FIFO with no pops.
    do_reset();
    store(30'h40, 32'h932, 0, 0);
    for (int i = 0; i < 9; i++) store(30'h40, 32'(10 + i), 0, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_wc", 32'(word_count), 32'd9);
    chk("ovf_head", out_data, 32'd10);
    out_ready = 1'b1;
    tick(10);
    chk("ovf_len", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) chk("ovf_last", log_q[7], 32'd17);

    // Full FIFO, store with a simultaneous pop.
    do_reset();
    store(30'h40, 32'h932, 0, 0);
    for (int i = 0; i < 8; i++) store(30'h40, 32'(20 + i), 0, 0);
    chk("full_noovf", 32'(overflow), 32'd0);
    mem_addr = 30'h40;
    mem_wdata = 32'd99;
    mem_wen = 1'b1;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    mem_wen = 1'b0;
    tick(1);
    chk("popush_ovf", 32'(overflow), 32'd0);
    chk("popush_wc", 32'(word_count), 32'd9);
    out_ready = 1'b1;
    tick(10);
    chk("popush_len", 32'(log_q.size()), 32'd9);
    if (log_q.size() == 9) chk("popush_last", log_q[8], 32'd99);

    // Reset in the middle of a capture.
    do_reset();
    store(30'h40, 32'h932, 0, 0);
    for (int i = 0; i < 3; i++) store(30'h40, 32'(40 + i), 0, 0);
    chk("mid_wc", 32'(word_count), 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_wc0", 32'(word_count), 32'd0);
    chk("mid_armed", 32'(armed), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    store(30'h40, 32'h7, 0, 0);
    tick(1);
    chk("post_armed", 32'(armed), 32'd0);
    chk("post_valid", 32'(out_valid), 32'd0);
`ifdef TESTPORT_STAMP_EN
    store(30'h40, 32'h932, 0, 0);
    tick(9);
    store(30'h40, 32'd55, 0, 0);
    out_ready = 1'b1;
    tick(3);
    chk("stamp_len", 32'(slog_q.size()), 32'd1);
    if (slog_q.size() > 0) chk("stamp_val", 32'(slog_q[0]), 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
